test_result_reporter: RTL and testbench
=======================================

TEST_RESULT_REPORTER -- requirements
Module: test_result_reporter

Interface
REQ-001 Parameter NUM_CHECKS, default 4, number of checker results that completes one test run (>=1).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles a run may stay active before forced report (>=2).
REQ-003 Parameter CNT_W, default $clog2(NUM_CHECKS+1), width of check/fail counters.
REQ-004 Port clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  single-cycle request from the test sequencer to begin a run.
REQ-007 Port check_valid  input  1  one checker result presented this cycle.
REQ-008 Port check_pass  input  1  result of the check; qualified by check_valid.
REQ-009 Port done  output  2  packed {passed, done} to the sequencer; bit0 = run complete pulse, bit1 = run passed.
REQ-010 Port busy  output  1  high while a run is active (RUNNING or REPORT).
REQ-011 Port check_cnt  output  CNT_W  checks received in current/last run.
REQ-012 Port fail_cnt  output  CNT_W  failing checks in current/last run.
REQ-013 Port timed_out  output  1  last run ended by timeout.

Function
REQ-014 FSM states IDLE, RUNNING, REPORT; encoding free.
REQ-015 IDLE + start=1 -> RUNNING next cycle; same edge clears check_cnt, fail_cnt, timed_out and cycle timer.
REQ-016 start in RUNNING or REPORT ignored; no restart, no counter clear.
REQ-017 RUNNING: check_valid=1 increments check_cnt by 1; additionally increments fail_cnt if check_pass=0.
REQ-018 check_valid in IDLE or REPORT ignored; counters hold.
REQ-019 RUNNING: cycle timer increments every cycle, starting at 0 on the first RUNNING cycle.
REQ-020 RUNNING -> REPORT on the edge where check_cnt reaches NUM_CHECKS (counting the check accepted that cycle).
REQ-021 RUNNING -> REPORT with timed_out=1 on the edge where timer equals TIMEOUT_CYCLES-1 and completion condition not met.
REQ-022 Completion and timeout on same cycle: completion wins, timed_out=0.
REQ-023 REPORT lasts exactly one cycle, then IDLE; done[0]=1 only in REPORT.
REQ-024 done[1]=1 in REPORT iff fail_cnt==0 and timed_out==0; done[1]=0 whenever done[0]=0.
REQ-025 done, busy registered outputs (driven from state/registers, no combinational path from inputs).
REQ-026 Latency: final check accepted in cycle N -> done[0] high in cycle N+1.
REQ-027 Counters never exceed NUM_CHECKS; no wrap-around possible since run ends at NUM_CHECKS.
REQ-028 check_cnt, fail_cnt, timed_out hold their values in IDLE after a run until next accepted start.
REQ-029 Back-to-back: start asserted in the IDLE cycle right after REPORT shall be accepted.

Reset
REQ-030 rst_n=0 forces, asynchronously: state IDLE, done=2'b00, busy=0, check_cnt=0, fail_cnt=0, timed_out=0, timer=0.
REQ-031 Reset mid-run aborts with no done pulse; after rst_n deasserts, block waits in IDLE for start.
REQ-032 Outputs stable and defined from first cycle after rst_n deassertion; start sampled only when rst_n=1.

Verification (NUM_CHECKS=4, TIMEOUT_CYCLES=16)
REQ-033 start, then 4 passing checks on consecutive cycles -> done=2'b11 one cycle after 4th check, check_cnt=4, fail_cnt=0, busy low next cycle.
REQ-034 start, checks pass,fail,pass,fail with idle gaps -> done=2'b01, fail_cnt=2, timed_out=0.
REQ-035 start, only 2 checks -> done=2'b01 on 17th cycle after start acceptance (timer 15), timed_out=1, check_cnt=2.
REQ-036 4th check arrives on timer=15 -> done=2'b11, timed_out=0.
REQ-037 Extra start pulses and check_valid while IDLE/REPORT -> counters unchanged, single done pulse per run; start in cycle after REPORT starts new run.
REQ-038 rst_n low after 2 checks -> outputs zero immediately (async), no done pulse; subsequent full passing run -> done=2'b11.

Source files
------------

// File: rtl/test_result_reporter.sv
// ---------------------------------------------------------------------------
// test_result_reporter
//
// Collects pass/fail results from checkers during one test run and reports a
// single verdict to the test sequencer. A run starts on a start request while
// idle. It completes once NUM_CHECKS results have been accepted. It is forced
// to finish if it stays active for TIMEOUT_CYCLES cycles. The verdict is
// shown for exactly one cycle in the REPORT state.
//
// Ports
//   i_clk          system clock, all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        single-cycle request to begin a run (honoured only in IDLE)
//   i_check_valid  one checker result is presented this cycle
//   i_check_pass   result of that check, qualified by i_check_valid
//   o_done         {passed, done}: bit0 pulses in REPORT, bit1 = run passed
//   o_busy         high while a run is active (RUNNING or REPORT)
//   o_check_cnt    checks received in the current/last run
//   o_fail_cnt     failing checks in the current/last run
//   o_timed_out    last run was ended by the timeout
// ---------------------------------------------------------------------------
module test_result_reporter #(
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_check_valid,
  input  logic             i_check_pass,
  output logic [1:0]       o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_check_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic             o_timed_out
);

  // The run timer only has to reach TIMEOUT_CYCLES-1.
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(NUM_CHECKS - 1);
  localparam logic [TMR_W-1:0] LAST_TICK  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_REPORT
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_check_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_timed_out;
  logic             r_busy;
  logic [1:0]       r_done;

  logic             w_is_fail;
  logic             w_complete;
  logic             w_expire;
  logic [CNT_W-1:0] w_fail_next;

  // The completion test looks at the count before this cycle's check. That
  // lets the final check end the run on the same edge that accepts it.
  assign w_is_fail   = i_check_valid & ~i_check_pass;
  assign w_complete  = i_check_valid && (r_check_cnt == LAST_CHECK);
  assign w_expire    = (r_timer == LAST_TICK);
  assign w_fail_next = r_fail_cnt + CNT_W'(w_is_fail);

  // Whole controller in one block. The done/busy registers are loaded on the
  // edge that enters the state they describe, so they are never decoded
  // from inputs. Completion is tested first so that it beats a timeout
  // landing on the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_check_cnt <= '0;
      r_fail_cnt  <= '0;
      r_timed_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 2'b00;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_RUNNING;
            r_timer     <= '0;
            r_check_cnt <= '0;
            r_fail_cnt  <= '0;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (i_check_valid) begin
            r_check_cnt <= r_check_cnt + CNT_W'(1);
            r_fail_cnt  <= w_fail_next;
          end
          if (w_complete) begin
            r_state <= ST_REPORT;
            r_done  <= {(w_fail_next == '0), 1'b1};
          end else if (w_expire) begin
            r_state     <= ST_REPORT;
            r_timed_out <= 1'b1;
            r_done      <= 2'b01;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_REPORT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_check_cnt = r_check_cnt;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_timed_out = r_timed_out;

endmodule

// File: tb/tb_test_result_reporter.sv
// ---------------------------------------------------------------------------
// tb_test_result_reporter
//
// Drives runs of the reporter with NUM_CHECKS=4 and TIMEOUT_CYCLES=16. Each
// run follows a per-cycle check schedule. The expected outcome of a run is
// worked out from its whole schedule before it is driven: which cycle ends
// the run, how many checks and failures are counted, and whether it timed
// out. The DUT outputs are then compared against that outcome cycle by cycle.
// ---------------------------------------------------------------------------
module tb_test_result_reporter;

   localparam int NC = 4;
   localparam int TO = 16;
   localparam int CW = $clog2(NC + 1);

   logic          clk = 1'b0;
   logic          rstN = 1'b1;
   logic          start = 1'b0;
   logic          checkValid = 1'b0;
   logic          checkPass = 1'b0;
   logic [1:0]    done;
   logic          busy;
   logic [CW-1:0] checkCnt;
   logic [CW-1:0] failCnt;
   logic          timedOut;

   int assertCount = 0;
   int failCount = 0;

   bit schedValid [TO];
   bit schedPass [TO];
   int expEnd;
   int expChecks;
   int expFails;
   bit expTimedOut;

   test_result_reporter #(
      .NUM_CHECKS(NC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_start(start),
      .i_check_valid(checkValid),
      .i_check_pass(checkPass),
      .o_done(done),
      .o_busy(busy),
      .o_check_cnt(checkCnt),
      .o_fail_cnt(failCnt),
      .o_timed_out(timedOut)
   );

   // Free-running clock; inputs change and outputs are sampled on the negedge
   always #5 clk = ~clk;

   // Count every comparison and report any mismatch
   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Work out the outcome of a run from its whole schedule: the run ends
   // once the NC-th check arrives, or after TO running cycles otherwise
   function automatic void computeExpect();
      int c = 0;
      int f = 0;
      expEnd = TO - 1;
      expTimedOut = 1'b1;
      for (int k = 0; k < TO; k++) begin
         if (schedValid[k]) begin
            c++;
            if (!schedPass[k]) f++;
         end
         if (c == NC) begin
            expEnd = k;
            expTimedOut = 1'b0;
            break;
         end
      end
      expChecks = c;
      expFails = f;
   endfunction

   // Reset the schedule to "no checks at all"
   function automatic void clearSched();
      for (int k = 0; k < TO; k++) begin
         schedValid[k] = 1'b0;
         schedPass[k] = 1'b0;
      end
   endfunction

   // Fill the schedule with random checks at the given density (percent)
   function automatic void randomSched(input int validPct, input int passPct);
      for (int k = 0; k < TO; k++) begin
         schedValid[k] = ($urandom_range(0, 99) < validPct);
         schedPass[k] = ($urandom_range(0, 99) < passPct);
      end
   endfunction

   // Idle cycles carrying check noise. Counters and done must stay put.
   task automatic idleCycles(input string name, input int n);
      int holdChecks;
      int holdFails;
      int holdTo;
      holdChecks = checkCnt;
      holdFails = failCnt;
      holdTo = timedOut;
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         checkValid = 1'($urandom_range(0, 1));
         checkPass = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         checkOutput({name, ".idleDone"}, done, 0);
         checkOutput({name, ".idleBusy"}, busy, 0);
         checkOutput({name, ".idleChecks"}, checkCnt, holdChecks);
         checkOutput({name, ".idleFails"}, failCnt, holdFails);
         checkOutput({name, ".idleTimedOut"}, timedOut, holdTo);
      end
      checkValid = 1'b0;
   endtask

   // Drive one run from an IDLE negedge and follow it to the next IDLE cycle.
   // A fresh run may be launched straight from the final IDLE cycle.
   task automatic applyStimulus(input string name);
      int seen;
      computeExpect();
      start = 1'b1;
      checkValid = 1'($urandom_range(0, 1));
      checkPass = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      seen = 0;
      for (int k = 0; k <= expEnd; k++) begin
         checkOutput({name, ".runDone"}, done, 0);
         checkOutput({name, ".runBusy"}, busy, 1);
         checkOutput({name, ".runChecks"}, checkCnt, seen);
         start = 1'($urandom_range(0, 1));
         checkValid = schedValid[k];
         checkPass = schedPass[k];
         if (schedValid[k]) seen++;
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput({name, ".reportDone"}, done,
                  (expFails == 0 && !expTimedOut) ? 3 : 1);
      checkOutput({name, ".reportBusy"}, busy, 1);
      checkOutput({name, ".reportChecks"}, checkCnt, expChecks);
      checkOutput({name, ".reportFails"}, failCnt, expFails);
      checkOutput({name, ".reportTimedOut"}, timedOut, expTimedOut);
      start = 1'($urandom_range(0, 1));
      checkValid = 1'($urandom_range(0, 1));
      checkPass = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkValid = 1'b0;
      checkOutput({name, ".afterDone"}, done, 0);
      checkOutput({name, ".afterBusy"}, busy, 0);
      checkOutput({name, ".afterChecks"}, checkCnt, expChecks);
      checkOutput({name, ".afterFails"}, failCnt, expFails);
      checkOutput({name, ".afterTimedOut"}, timedOut, expTimedOut);
   endtask

   // Start a run, take two checks, then pull reset in mid-cycle
   task automatic resetMidRun();
      int pulses;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checkValid = 1'b1;
         checkPass = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      checkValid = 1'b0;
      checkOutput("rst.preChecks", checkCnt, 2);
      #2 rstN = 1'b0;
      #1;
      checkOutput("rst.asyncDone", done, 0);
      checkOutput("rst.asyncBusy", busy, 0);
      checkOutput("rst.asyncChecks", checkCnt, 0);
      checkOutput("rst.asyncFails", failCnt, 0);
      checkOutput("rst.asyncTimedOut", timedOut, 0);
      @(negedge clk);
      rstN = 1'b1;
      pulses = 0;
      for (int i = 0; i < TO + 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done != 2'b00 || busy) pulses++;
      end
      checkOutput("rst.noDonePulse", pulses, 0);
   endtask

   initial begin
      // Create a real falling edge on reset so the async path is exercised
      #1 rstN = 1'b0;
      #1;
      checkOutput("reset.done", done, 0);
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.checks", checkCnt, 0);
      checkOutput("reset.fails", failCnt, 0);
      checkOutput("reset.timedOut", timedOut, 0);
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      rstN = 1'b1;
      idleCycles("postReset", 2);

      // Four passing checks back to back
      clearSched();
      for (int k = 0; k < 4; k++) begin
         schedValid[k] = 1'b1;
         schedPass[k] = 1'b1;
      end
      applyStimulus("allPass");

      // pass, fail, pass, fail with gaps, launched back to back
      clearSched();
      for (int k = 0; k < 4; k++) begin
         schedValid[2*k] = 1'b1;
         schedPass[2*k] = (k % 2 == 0);
      end
      applyStimulus("mixed");
      idleCycles("gap1", 3);

      // Only two checks: forced report after the timeout
      clearSched();
      schedValid[1] = 1'b1;
      schedPass[1] = 1'b1;
      schedValid[5] = 1'b1;
      schedPass[5] = 1'b1;
      applyStimulus("timeout");

      // Fourth check on the last timer value: completion beats timeout
      clearSched();
      for (int k = 0; k < 3; k++) begin
         schedValid[k] = 1'b1;
         schedPass[k] = 1'b1;
      end
      schedValid[TO-1] = 1'b1;
      schedPass[TO-1] = 1'b1;
      applyStimulus("lastTick");

      // No checks at all
      clearSched();
      applyStimulus("empty");
      idleCycles("gap2", 2);

      // Random runs at varying densities, some back to back
      for (int r = 0; r < 40; r++) begin
         randomSched((r % 3 == 0) ? 15 : 50, 75);
         applyStimulus($sformatf("rand%0d", r));
         if ($urandom_range(0, 1) == 1) idleCycles($sformatf("randGap%0d", r), 1);
      end

      // Reset during a run, then a complete passing run
      resetMidRun();
      clearSched();
      for (int k = 0; k < 4; k++) begin
         schedValid[k] = 1'b1;
         schedPass[k] = 1'b1;
      end
      applyStimulus("afterReset");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
